pipe_mux_stage: RTL and testbench
=================================

// Module: pipe_mux_stage
// PURPOSE
//  - Parametrised N-way, WIDTH-bit multiplexer with a registered, flow-controlled output stage.
//  - Selects one of NUM_IN input words per accepted transfer and holds it in a 2-entry skid buffer.
//  - Provides a valid/ready handshake on both sides at full throughput.
//  - Sits between pipeline stages of the datapath: writeback/forwarding source select, PC source select.
// PARAMETERS
//  WIDTH   32  bits per data word
//  NUM_IN  4   number of input words (2..16); need not be a power of two
//  SEL_W   derived = (NUM_IN<=2)?1:$clog2(NUM_IN); not overridden
// PORTS
//  clock      in   1              rising-edge clock
//  reset_n    in   1              asynchronous, active-low reset
//  data_in    in   NUM_IN*WIDTH   packed inputs; word k = data_in[k*WIDTH +: WIDTH]
//  select     in   SEL_W          index of the word to capture
//  in_valid   in   1              upstream presents data_in/select
//  in_ready   out  1              stage can accept this cycle
//  out_data   out  WIDTH          selected word (registered)
//  out_valid  out  1              out_data holds a valid word
//  out_ready  in   1              downstream accepts out_data this cycle
//  sel_error  out  1              sticky out-of-range-select flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset_n=0, any time, asynchronous):
//    - out_valid=0, out_data=0, in_ready=1, skid entry empty, sel_error=0.
//    - Any in-flight words are discarded.
//  - Handshake rules:
//    - Input transfer: in_valid & in_ready at a rising edge.
//    - Output transfer: out_valid & out_ready at a rising edge.
//    - in_ready is a register: 1 iff the skid entry is empty. It does not depend combinationally on out_ready.
//    - out_valid/out_data never change while out_valid=1 & out_ready=0.
//  - Captured value:
//    - select < NUM_IN: word[select].
//    - select >= NUM_IN: WIDTH'b0.
//  - Latency: 1 cycle (input transfer at edge N gives out_valid=1 after edge N when the main register is free).
//  - States (main M, skid S):
//    - EMPTY (M empty, S empty)
//      - in xfer -> ONE (M=captured).
//    - ONE (M full, S empty)
//      - in & out xfer -> ONE (M=captured).
//      - out only -> EMPTY.
//      - in only -> FULL (S=captured, in_ready->0).
//      - neither -> ONE.
//    - FULL (M full, S full; in_ready=0, so no input transfer)
//      - out xfer -> ONE (M<=S, S empty, in_ready->1).
//      - otherwise hold.
//  - Throughput: 1 word/cycle sustained while out_ready=1. No word lost or duplicated. Order preserved.
//  - out_ready=0 with in_valid=1: exactly 2 words are absorbed, then in_ready=0.
//  - Simultaneous in and out transfer in ONE: old M leaves and new word enters in the same edge.
//  - in_valid=0: select and data_in are don't-care and have no side effects.
// CONFIGURATION
//  - Macro PIPE_MUX_SEL_CHECK_EN:
//    - Defined: an input transfer with select >= NUM_IN sets sel_error=1.
//      sel_error holds until reset_n=0. The word is still captured as WIDTH'b0.
//    - Not defined: sel_error is tied to 0. Out-of-range select still captures 0.
//  - When NUM_IN is a power of two, out-of-range select is impossible and sel_error stays 0.
// TESTING
//  1. WIDTH=32, NUM_IN=4, out_ready=1; send select=0..3, data_in words 0x11,0x22,0x33,0x44 on consecutive cycles
//     -> out_data 0x11,0x22,0x33,0x44 on consecutive cycles, starting 1 cycle after the first transfer;
//     in_ready stays 1.
//  2. Hold out_ready=0; drive in_valid=1 with 0xA1,0xA2,0xA3
//     -> only 0xA1,0xA2 accepted; in_ready=0 from the cycle after the 2nd transfer;
//     after out_ready=1: out 0xA1 then 0xA2, then 0xA3 accepted.
//  3. Random in_valid/out_ready (50% each), 1000 words with an incrementing payload
//     -> scoreboard: exact order, no drops or duplicates; out_data stable while stalled.
//  4. NUM_IN=3, PIPE_MUX_SEL_CHECK_EN defined, select=3 with word0=0xFFFF_FFFF
//     -> out_data=0, sel_error=1 and stays 1 through later valid selects.
//     Same stimulus without the macro -> out_data=0, sel_error=0.
//  5. Assert reset_n=0 mid-burst in state FULL (asynchronous, between edges)
//     -> out_valid=0, out_data=0, in_ready=1 immediately;
//     after release, the first new word appears with 1-cycle latency.

Source files
------------

// File: rtl/pipe_mux_stage_if.sv
// rtl/pipe_mux_stage_if.sv - handshake/data bundle for pipe_mux_stage
// Upstream drives data_in/select/in_valid, downstream drives out_ready.
interface pipe_mux_stage_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = (NUM_IN <= 2) ? 1 : $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]        select;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output data_in, select, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  data_in, select, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/pipe_mux_stage.sv
// rtl/pipe_mux_stage.sv - N-way mux feeding a 2-entry skid buffer with valid/ready on both sides
// Optional macro PIPE_MUX_SEL_CHECK_EN enables the sticky out-of-range select flag.
module pipe_mux_stage #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    pipe_mux_stage_if.slave    bus,
    output logic               sel_error
);
    localparam int SEL_W = (NUM_IN <= 2) ? 1 : $clog2(NUM_IN);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [WIDTH-1:0] cap_word;
    logic             in_xfer;
    logic             out_xfer;

    // Out-of-range selects match no index and fall through to zero.
    always_comb begin
        cap_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.select == SEL_W'(k)) begin
                cap_word = bus.data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.in_ready  = (state_q != ST_FULL);
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_data  = main_q;

    assign in_xfer  = bus.in_valid & bus.in_ready;
    assign out_xfer = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_d  = cap_word;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = cap_word;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end else if (in_xfer) begin
                    skid_d  = cap_word;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_MUX_SEL_CHECK_EN
    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

    logic sel_err_q, sel_err_d;

    always_comb begin
        sel_err_d = sel_err_q | (in_xfer & ({1'b0, bus.select} >= NUM_IN_W));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_error = sel_err_q;
`else
    assign sel_error = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_mux_stage.sv
// tb/tb_pipe_mux_stage.sv - queue-model bench for pipe_mux_stage (NUM_IN=4 main, NUM_IN=3 select-range)
module tb_pipe_mux_stage;
`ifdef PIPE_MUX_SEL_CHECK_EN
    localparam logic [31:0] EXP_SELERR = 32'd1;
`else
    localparam logic [31:0] EXP_SELERR = 32'd0;
`endif

    logic clock;
    logic reset_n;
    logic sel_err4;
    logic sel_err3;
    int   checks = 0;
    int   errors = 0;
    int   rx_cnt = 0;

    pipe_mux_stage_if #(.WIDTH(32), .NUM_IN(4)) bus4 ();
    pipe_mux_stage_if #(.WIDTH(32), .NUM_IN(3)) bus3 ();

    pipe_mux_stage #(.WIDTH(32), .NUM_IN(4)) u4 (
        .clock(clock), .reset_n(reset_n), .bus(bus4), .sel_error(sel_err4)
    );
    pipe_mux_stage #(.WIDTH(32), .NUM_IN(3)) u3 (
        .clock(clock), .reset_n(reset_n), .bus(bus3), .sel_error(sel_err3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the stage is a FIFO of depth 2 with an input-side capture rule.
    logic [31:0] mq[$];

    function automatic logic [31:0] model_cap(input logic [127:0] d, input int sel);
        if (sel < 4) return d[sel*32 +: 32];
        return 32'd0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
        end else begin
            automatic bit ov = (mq.size() > 0);
            automatic bit ir = (mq.size() < 2);
            if (ov && bus4.out_ready) begin
                void'(mq.pop_front());
                rx_cnt++;
            end
            if (bus4.in_valid && ir) mq.push_back(model_cap(bus4.data_in, int'(bus4.select)));
        end
    end

    always @(negedge clock) begin
        chk("in_ready", 32'(bus4.in_ready), 32'(mq.size() < 2));
        chk("out_valid", 32'(bus4.out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) chk("out_data", bus4.out_data, mq[0]);
        if (!reset_n) chk("out_data_rst", bus4.out_data, 32'd0);
        chk("sel_error_pow2", 32'(sel_err4), 32'd0);
    end

    task automatic rand_data4();
        for (int j = 0; j < 4; j++) bus4.data_in[j*32 +: 32] = $urandom;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] t1_words[4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    initial begin
        int sent;
        int rx_base;
        int cyc;
        bit acc;

        reset_n = 1'b0;
        bus4.data_in = '0; bus4.select = '0; bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
        bus3.data_in = '0; bus3.select = '0; bus3.in_valid = 1'b0; bus3.out_ready = 1'b1;
        #11;
        chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst_out_data", bus4.out_data, 32'd0);
        chk("rst_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("rst_sel_error3", 32'(sel_err3), 32'd0);
        #1 reset_n = 1'b1;
        step();

        // 1: back-to-back with out_ready=1
        bus4.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rand_data4();
            bus4.in_valid = 1'b1;
            bus4.select = 2'(k);
            bus4.data_in[k*32 +: 32] = t1_words[k];
            step();
            chk("t1_out_data", bus4.out_data, t1_words[k]);
            chk("t1_out_valid", 32'(bus4.out_valid), 32'd1);
            chk("t1_in_ready", 32'(bus4.in_ready), 32'd1);
        end
        bus4.in_valid = 1'b0;
        step();
        chk("t1_drained", 32'(bus4.out_valid), 32'd0);

        // 2: stall absorbs exactly two words
        bus4.out_ready = 1'b0;
        bus4.in_valid = 1'b1;
        bus4.select = 2'd2;
        rand_data4(); bus4.data_in[64 +: 32] = 32'hA1;
        step();
        chk("t2_in_ready_1", 32'(bus4.in_ready), 32'd1);
        rand_data4(); bus4.data_in[64 +: 32] = 32'hA2;
        step();
        chk("t2_in_ready_full", 32'(bus4.in_ready), 32'd0);
        chk("t2_hold_a1", bus4.out_data, 32'hA1);
        rand_data4(); bus4.data_in[64 +: 32] = 32'hA3;
        step();
        chk("t2_still_full", 32'(bus4.in_ready), 32'd0);
        chk("t2_still_a1", bus4.out_data, 32'hA1);
        bus4.out_ready = 1'b1;
        step();
        chk("t2_out_a2", bus4.out_data, 32'hA2);
        chk("t2_ready_again", 32'(bus4.in_ready), 32'd1);
        step();
        chk("t2_out_a3", bus4.out_data, 32'hA3);
        bus4.in_valid = 1'b0;
        step();
        chk("t2_empty", 32'(bus4.out_valid), 32'd0);

        // 3: random handshakes, incrementing payload
        sent = 0;
        rx_base = rx_cnt;
        cyc = 0;
        while ((sent < 1000 || (rx_cnt - rx_base) < 1000) && cyc < 20000) begin
            bus4.out_ready = 1'($urandom % 2);
            if (sent < 1000) begin
                rand_data4();
                bus4.in_valid = 1'($urandom % 2);
                bus4.select = 2'($urandom % 4);
                bus4.data_in[int'(bus4.select)*32 +: 32] = 32'h1000_0000 + 32'(sent);
            end else begin
                bus4.in_valid = 1'b0;
            end
            acc = bus4.in_valid && (mq.size() < 2);
            step();
            if (acc) sent++;
            cyc++;
        end
        bus4.in_valid = 1'b0;
        chk("t3_sent", 32'(sent), 32'd1000);
        chk("t3_received", 32'(rx_cnt - rx_base), 32'd1000);
        bus4.out_ready = 1'b1;
        step();

        // 4: out-of-range select on NUM_IN=3
        bus3.in_valid = 1'b1;
        bus3.select = 2'd3;
        bus3.data_in = {3{32'hFFFF_FFFF}};
        step();
        chk("t4_oor_data", bus3.out_data, 32'd0);
        chk("t4_oor_valid", 32'(bus3.out_valid), 32'd1);
        chk("t4_sel_error", 32'(sel_err3), EXP_SELERR);
        bus3.select = 2'd1;
        bus3.data_in = {32'hFFFF_FFFF, 32'h55, 32'hFFFF_FFFF};
        step();
        chk("t4_valid_sel_data", bus3.out_data, 32'h55);
        chk("t4_sel_error_sticky", 32'(sel_err3), EXP_SELERR);
        bus3.in_valid = 1'b0;
        step();
        chk("t4_sel_error_hold", 32'(sel_err3), EXP_SELERR);

        // 5: asynchronous reset while FULL
        bus4.out_ready = 1'b0;
        bus4.in_valid = 1'b1;
        bus4.select = 2'd0;
        rand_data4(); bus4.data_in[0 +: 32] = 32'hB1;
        step();
        rand_data4(); bus4.data_in[0 +: 32] = 32'hB2;
        step();
        chk("t5_full", 32'(bus4.in_ready), 32'd0);
        bus4.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("t5_rst_out_data", bus4.out_data, 32'd0);
        chk("t5_rst_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("t5_rst_sel_error", 32'(sel_err3), 32'd0);
        @(negedge clock);
        #3 reset_n = 1'b1;
        bus4.out_ready = 1'b1;
        bus4.in_valid = 1'b1;
        bus4.select = 2'd1;
        rand_data4(); bus4.data_in[32 +: 32] = 32'h77;
        step();
        chk("t5_first_data", bus4.out_data, 32'h77);
        chk("t5_first_valid", 32'(bus4.out_valid), 32'd1);
        bus4.in_valid = 1'b0;
        step();
        chk("t5_drained", 32'(bus4.out_valid), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
